mem_responder: RTL and testbench

Main-memory responder on the far side of the cache-to-memory interface: it accepts one cache-line read (fill) or write (writeback) request at a time, models the fixed request and response transit delays, then returns a response carrying the line data or a write acknowledge. It sits below the instruction and data caches, or below an arbiter in front of them. It is the behavioural main memory used in the core testbench and in simulation builds.

---
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: behavioural main memory behind the cache-to-memory interface.
// Holds one outstanding line read or write at a time. It models fixed request
// and response transit delays, then presents the response until it is taken.
module mem_responder #(
  parameter int    LINE_BITS  = 128,
  parameter int    ADDR_BITS  = 32,
  parameter int    NUM_LINES  = 4096,
  parameter int    REQ_DELAY  = 5,
  parameter int    RESP_DELAY = 5,
  parameter string INIT_FILE  = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_we,
  output logic [ADDR_BITS-1:0] resp_addr,
  output logic [LINE_BITS-1:0] resp_rdata
);

  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int IDX   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int MAXD  = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int CNT_W = (MAXD > 1) ? $clog2(MAXD) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ_WAIT  = 2'd1,
    RESP_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic accept;
  logic access;

  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic [ADDR_BITS-1:0] addr_aligned;
  logic [IDX-1:0]       line_idx;

  // Storage is deliberately left out of reset; only writes define it.
  logic [LINE_BITS-1:0] mem [NUM_LINES];

  // Offset bits are dropped; bits above the index alias onto the same line.
  assign addr_aligned = {req_addr[ADDR_BITS-1:OFF], {OFF{1'b0}}};
  assign line_idx     = addr_q[OFF +: IDX];

  // Handshake flags are decoded from state alone, never from the request inputs.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_we    = we_q;
  assign resp_addr  = addr_q;
  assign resp_rdata = rdata_q;

  // State and transit-delay counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: count down the request leg, access the array, count the response leg.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(REQ_DELAY - 1);
          state_nxt = REQ_WAIT;
        end
      end
      REQ_WAIT: begin
        if (cnt == '0) begin
          access    = 1'b1;
          cnt_nxt   = CNT_W'(RESP_DELAY - 1);
          state_nxt = RESP_WAIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP_WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and response data; these are visible outputs so they reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q   <= req_we;
        addr_q <= addr_aligned;
      end
      if (access) rdata_q <= we_q ? '0 : mem[line_idx];
    end
  end

  // Write data only matters once captured, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= req_wdata;
  end

  // Array write at the end of the request leg; a reset before this edge cancels it.
  always_ff @(posedge clk) begin
    if (access && we_q) mem[line_idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder (16-line array to exercise aliasing).
module tb_mem_responder;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_we;
  logic [31:0]  resp_addr;
  logic [127:0] resp_rdata;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] L1  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] LAA = {16{8'hAA}};
  localparam logic [127:0] L11 = {16{8'h11}};
  localparam logic [127:0] L55 = {16{8'h55}};

  mem_responder #(
    .LINE_BITS (128),
    .ADDR_BITS (32),
    .NUM_LINES (16),
    .REQ_DELAY (5),
    .RESP_DELAY(5),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_we   (resp_we),
    .resp_addr (resp_addr),
    .resp_rdata(resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and return just after the accepting edge.
  task automatic accept(input logic we, input logic [31:0] addr, input logic [127:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && n < 40) begin
      tick;
      n++;
    end
    chk("accept_ready", 128'(req_ready), 128'd1);
    tick;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Count edges after acceptance until resp_valid shows; notes any req_ready seen meanwhile.
  task automatic wait_resp(output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    while (!resp_valid && lat < 40) begin
      if (req_ready) rdy_seen = 1'b1;
      tick;
      lat++;
    end
    if (req_ready) rdy_seen = 1'b1;
  endtask

  // Full transaction with immediate response acceptance.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [127:0] wd, input logic [31:0] exp_addr,
                     input logic [127:0] exp_data);
    int lat;
    bit rs;
    accept(we, addr, wd);
    wait_resp(lat, rs);
    chk({tag, "_lat"}, 128'(lat), 128'd10);
    chk({tag, "_we"}, 128'(resp_we), 128'(we));
    chk({tag, "_addr"}, 128'(resp_addr), 128'(exp_addr));
    chk({tag, "_data"}, resp_rdata, exp_data);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk({tag, "_rdy_after"}, 128'({req_ready, resp_valid}), 128'b10);
  endtask

  initial begin
    int lat;
    int hi;
    int got;
    int issued;
    int last;
    int gap;
    bit rs;
    bit seen;
    bit acc;
    logic [31:0]  sa [4];
    logic [127:0] sd [4];

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    // Reset
    tick; tick; tick;
    chk("rst_low_flags", 128'({req_ready, resp_valid}), 128'b10);
    chk("rst_low_outs", 128'({resp_we, resp_addr}), 128'd0);
    chk("rst_low_rdata", resp_rdata, 128'd0);
    rst_n = 1'b1;
    tick;
    chk("rst_rel_flags", 128'({req_ready, resp_valid}), 128'b10);
    chk("rst_rel_outs", 128'({resp_we, resp_addr}), 128'd0);

    // Write then read back (offset bits ignored)
    txn("wr100", 1'b1, 32'h100, L1, 32'h100, 128'd0);
    txn("rd10c", 1'b0, 32'h10C, 128'd0, 32'h100, L1);

    // Latency and backpressure
    accept(1'b0, 32'h104, 128'd0);
    wait_resp(lat, rs);
    chk("bp_lat", 128'(lat), 128'd10);
    hi = 0;
    for (int i = 0; i < 7; i++) begin
      if (resp_valid) hi++;
      if (req_ready) rs = 1'b1;
      chk("bp_stable_data", resp_rdata, L1);
      tick;
    end
    if (resp_valid) hi++;
    if (req_ready) rs = 1'b1;
    chk("bp_stable_addr", 128'({resp_we, resp_addr}), 128'h100);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("bp_valid_cycles", 128'(hi), 128'd8);
    chk("bp_req_ready_low", 128'(rs), 128'd0);
    chk("bp_after_hs", 128'({req_ready, resp_valid}), 128'b10);

    // Aliasing: 0x100 and 0x000 share line 0 in a 16-line array
    txn("alias_wr", 1'b1, 32'h000, LAA, 32'h000, 128'd0);
    txn("alias_rd", 1'b0, 32'h100, 128'd0, 32'h100, LAA);

    // Reset before commit cancels the write
    txn("pre_wr40", 1'b1, 32'h40, L11, 32'h40, 128'd0);
    accept(1'b1, 32'h40, L55);
    tick; tick; tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", 128'({req_ready, resp_valid}), 128'b10);
    tick; tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (resp_valid) seen = 1'b1;
    end
    chk("mid_rst_no_resp", 128'(seen), 128'd0);
    txn("rd40_old", 1'b0, 32'h40, 128'd0, 32'h40, L11);

    // Reset after commit keeps the write
    accept(1'b1, 32'h40, L55);
    for (int i = 0; i < 7; i++) tick;
    rst_n = 1'b0;
    #1;
    chk("late_rst_flags", 128'({req_ready, resp_valid}), 128'b10);
    tick; tick;
    rst_n = 1'b1;
    tick;
    txn("rd40_new", 1'b0, 32'h40, 128'd0, 32'h40, L55);

    // Back-to-back streaming
    sa[0] = 32'h00; sa[1] = 32'h10; sa[2] = 32'h20; sa[3] = 32'h30;
    sd[0] = {4{32'hC0DE_0000}};
    sd[1] = {4{32'hC0DE_1111}};
    sd[2] = {4{32'hC0DE_2222}};
    sd[3] = {4{32'hC0DE_3333}};
    for (int i = 0; i < 4; i++) txn("stream_fill", 1'b1, sa[i], sd[i], sa[i], 128'd0);
    got = 0;
    issued = 0;
    last = 0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = sa[0];
    resp_ready = 1'b1;
    for (int c = 0; c < 80 && got < 4; c++) begin
      acc = req_ready;
      if (resp_valid) begin
        chk("stream_data", resp_rdata, sd[got]);
        chk("stream_addr", 128'(resp_addr), 128'(sa[got]));
        if (got > 0) begin
          gap = c - last;
          chk("stream_gap", 128'(gap), 128'd12);
        end
        last = c;
        got++;
      end
      tick;
      if (acc && issued < 4) begin
        issued++;
        if (issued < 4) req_addr = sa[issued];
        else req_valid = 1'b0;
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    chk("stream_count", 128'(got), 128'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
